// File: rtl/match_req_if.sv
// ---------------------------------------------------------------------------
// match_req_if
// Bundles the group-input handshake and the per-channel match-request
// outputs of the match request dispatcher.
//   in_valid / in_ready   : group handshake
//   in_mask               : live bit per request in the group
//   in_offset             : LAZY_LEN offsets, request i in slice i
//   in_route_map          : LAZY_LEN eligible-channel bitmaps, request i in slice i
//   ch_valid / ch_ready   : per-channel request handshake
//   ch_offset             : NUM_CH offsets, channel j in slice j
//   ch_idx                : NUM_CH request-index tags, channel j in slice j
// master = group producer and channel consumers, slave = dispatcher.
// ---------------------------------------------------------------------------
interface match_req_if #(
   parameter int LAZY_LEN    = 4,
   parameter int NUM_CH      = 4,
   parameter int OFFSET_BITS = 20,
   parameter int IDX_BITS    = 2
);
   logic                            in_valid;
   logic                            in_ready;
   logic [LAZY_LEN-1:0]             in_mask;
   logic [LAZY_LEN*OFFSET_BITS-1:0] in_offset;
   logic [LAZY_LEN*NUM_CH-1:0]      in_route_map;
   logic [NUM_CH-1:0]               ch_valid;
   logic [NUM_CH-1:0]               ch_ready;
   logic [NUM_CH*OFFSET_BITS-1:0]   ch_offset;
   logic [NUM_CH*IDX_BITS-1:0]      ch_idx;

   modport master (
      output in_valid, in_mask, in_offset, in_route_map, ch_ready,
      input  in_ready, ch_valid, ch_offset, ch_idx
   );

   modport slave (
      input  in_valid, in_mask, in_offset, in_route_map, ch_ready,
      output in_ready, ch_valid, ch_offset, ch_idx
   );
endinterface

// File: rtl/match_req_dispatcher.sv
// ---------------------------------------------------------------------------
// match_req_dispatcher
// Accepts a group of LAZY_LEN match requests, routes each live request to
// the lowest eligible channel of its route map and hands requests to the
// NUM_CH match channels. Requests sharing a channel leave in ascending
// index order. Live requests with no eligible channel are dropped and
// counted.
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus         : match_req_if slave (group input + channel outputs)
//   group_done  : one-cycle pulse after the last request of a group is
//                 handed off or dropped
//   busy        : high while a group is being dispatched
//   drop_cnt    : saturating count of dropped requests
// ---------------------------------------------------------------------------
module match_req_dispatcher #(
   parameter int LAZY_LEN    = 4,
   parameter int NUM_CH      = 4,
   parameter int OFFSET_BITS = 20,
   parameter int IDX_BITS    = 2
) (
   input  logic        clk,
   input  logic        rst,
   match_req_if.slave  bus,
   output logic        group_done,
   output logic        busy,
   output logic [15:0] drop_cnt
);

   localparam int CNT_W = $clog2(LAZY_LEN + 1);

   typedef enum logic {IDLE, DISPATCH} state_t;

   state_t                        state;
   logic                          in_ready_q;
   logic [LAZY_LEN-1:0]           pending;
   logic [OFFSET_BITS-1:0]        req_offset [LAZY_LEN];
   logic [NUM_CH-1:0]             req_sel    [LAZY_LEN];

   logic [NUM_CH-1:0]             ch_valid_q;
   logic [NUM_CH*OFFSET_BITS-1:0] ch_offset_q;
   logic [NUM_CH*IDX_BITS-1:0]    ch_idx_q;

   // Capture-side decode of the presented group
   logic [NUM_CH-1:0]             route     [LAZY_LEN];
   logic [NUM_CH-1:0]             cap_sel   [LAZY_LEN];
   logic [LAZY_LEN-1:0]           cap_pending;
   logic [CNT_W-1:0]              cap_drops;
   logic [16:0]                   drop_sum;
   logic [15:0]                   drop_next;

   // Dispatch-side arbitration
   logic [NUM_CH-1:0]             found;
   logic [NUM_CH-1:0]             load;
   logic [IDX_BITS-1:0]           grant_idx [NUM_CH];
   logic [LAZY_LEN-1:0]           pend_clr;
   logic [LAZY_LEN-1:0]           pending_next;

   // NOTE: every variable gets a default at the top of an always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cap_pending = '0;
      cap_drops   = '0;
      for (int i = 0; i < LAZY_LEN; i++) begin
         route[i]       = bus.in_route_map[i*NUM_CH +: NUM_CH];
         // x & -x isolates the lowest set bit: the preferred channel one-hot.
         cap_sel[i]     = route[i] & (~route[i] + NUM_CH'(1));
         cap_pending[i] = bus.in_mask[i] && (route[i] != '0);
         cap_drops      = cap_drops + CNT_W'(bus.in_mask[i] && (route[i] == '0));
      end
      drop_sum  = {1'b0, drop_cnt} + 17'(cap_drops);
      drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // Each channel picks the lowest-index pending request selecting it. A
   // request selects exactly one channel, so no request is granted twice.
   always_comb begin
      found    = '0;
      load     = '0;
      pend_clr = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         grant_idx[j] = '0;
         // Descending scan: the last hit written is the lowest index.
         for (int i = LAZY_LEN - 1; i >= 0; i--) begin
            if (pending[i] && req_sel[i][j]) begin
               found[j]     = 1'b1;
               grant_idx[j] = IDX_BITS'(i);
            end
         end
         load[j] = (state == DISPATCH) && found[j] &&
                   (!ch_valid_q[j] || bus.ch_ready[j]);
         if (load[j]) pend_clr[grant_idx[j]] = 1'b1;
      end
      pending_next = pending & ~pend_clr;
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready_q <= 1'b1;
         busy       <= 1'b0;
         group_done <= 1'b0;
         pending    <= '0;
         drop_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  pending  <= cap_pending;
                  drop_cnt <= drop_next;
                  if (cap_pending != '0) begin
                     state      <= DISPATCH;
                     in_ready_q <= 1'b0;
                     busy       <= 1'b1;
                     group_done <= 1'b0;
                  end else begin
                     // Nothing to dispatch: the group completes at capture.
                     group_done <= 1'b1;
                  end
               end else begin
                  group_done <= 1'b0;
               end
            end
            DISPATCH: begin
               pending <= pending_next;
               if (pending_next == '0) begin
                  state      <= IDLE;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b0;
                  group_done <= 1'b1;
               end else begin
                  group_done <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               in_ready_q <= 1'b1;
               busy       <= 1'b0;
               group_done <= 1'b0;
               pending    <= '0;
            end
         endcase
      end
   end

   // NOTE: the request storage has no reset; its contents are only ever read
   // behind a pending bit, and the pending bits are reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.in_valid) begin
         for (int i = 0; i < LAZY_LEN; i++) begin
            req_offset[i] <= bus.in_offset[i*OFFSET_BITS +: OFFSET_BITS];
            req_sel[i]    <= cap_sel[i];
         end
      end
   end

   // Channel holding registers drain independently of the FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_valid_q  <= '0;
         ch_offset_q <= '0;
         ch_idx_q    <= '0;
      end else begin
         for (int j = 0; j < NUM_CH; j++) begin
            if (load[j]) begin
               ch_valid_q[j]                             <= 1'b1;
               ch_offset_q[j*OFFSET_BITS +: OFFSET_BITS] <= req_offset[grant_idx[j]];
               ch_idx_q[j*IDX_BITS +: IDX_BITS]          <= grant_idx[j];
            end else if (ch_valid_q[j] && bus.ch_ready[j]) begin
               ch_valid_q[j] <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.ch_valid  = ch_valid_q;
   assign bus.ch_offset = ch_offset_q;
   assign bus.ch_idx    = ch_idx_q;

endmodule

// File: doc/match_req_dispatcher.md
MATCH_REQ_DISPATCHER -- requirements
Module: match_req_dispatcher

Interface
REQ-001 Parameter LAZY_LEN, default 4: number of match requests carried per input group.
REQ-002 Parameter NUM_CH, default 4: number of match-request channels (match PEs).
REQ-003 Parameter OFFSET_BITS, default 20: width of one sequence offset.
REQ-004 Parameter IDX_BITS, default 2: width of the request-index tag, equal to clog2(LAZY_LEN).
REQ-005 Port clk, input, 1: the single clock; every register is clocked on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1: an input group is presented.
REQ-008 Port in_ready, output, 1: the dispatcher accepts the presented group.
REQ-009 Port in_mask, input, LAZY_LEN: bit i set means request i is live.
REQ-010 Port in_offset, input, LAZY_LEN*OFFSET_BITS: offset of request i in slice i.
REQ-011 Port in_route_map, input, LAZY_LEN*NUM_CH: eligible-channel bitmap of request i in slice i, as produced by the route table.
REQ-012 Port ch_valid, output, NUM_CH: channel j holds a request.
REQ-013 Port ch_ready, input, NUM_CH: channel j consumes its request.
REQ-014 Port ch_offset, output, NUM_CH*OFFSET_BITS: offset held for channel j.
REQ-015 Port ch_idx, output, NUM_CH*IDX_BITS: index i of the request held for channel j.
REQ-016 Port group_done, output, 1: one-cycle pulse when every request of the current group has been handed off or dropped.
REQ-017 Port busy, output, 1: high whenever the state is not IDLE.
REQ-018 Port drop_cnt, output, 16: saturating count of dropped requests.

Function
REQ-019 The FSM SHALL have two states: IDLE and DISPATCH.
REQ-020 in_ready SHALL be high only in IDLE.
REQ-021 An input handshake is in_valid && in_ready.
- On the handshake the block SHALL register, per request, the offset, a pending bit equal to in_mask[i] && (route_map_i != 0), and sel_i = the lowest set bit of route_map_i.
- The FSM SHALL then go to DISPATCH.
REQ-022 A request that is live with an all-zero route map SHALL be dropped at capture, and drop_cnt SHALL increase by the number of such requests, saturating at 0xFFFF.
REQ-023 If no request is pending after capture, the FSM SHALL stay in IDLE and group_done SHALL pulse in the next cycle.
REQ-024 In DISPATCH, channel j is free when ch_valid[j]==0 or ch_ready[j]==1.
- On each edge, every free channel j SHALL load the lowest-index pending request whose sel equals j, set ch_valid[j], and clear that request's pending bit.
- Each channel SHALL load at most one request per cycle.
REQ-025 A channel that is handshaking and has no candidate request SHALL clear ch_valid[j].
REQ-026 ch_valid, ch_offset and ch_idx SHALL hold stable while ch_valid[j] && !ch_ready[j].
REQ-027 Requests sharing one channel SHALL leave that channel in ascending index order.
REQ-028 Latency: a request routed to an idle channel SHALL appear on ch_valid exactly one edge after capture.
REQ-029 When the pending bits become all zero, the FSM SHALL return to IDLE on that edge and group_done SHALL be high for the following cycle.
- Outstanding ch_valid entries do not delay group_done.
- A new group may be captured in that same cycle.
- Channel registers keep draining independently of the FSM state.
REQ-030 If a new group's request targets a channel still holding an unconsumed request, that request SHALL wait until the channel is free.

Reset
REQ-031 While rst is high, the block SHALL force: state IDLE, all pending bits 0, ch_valid 0, ch_offset 0, ch_idx 0, group_done 0, busy 0, drop_cnt 0.
- in_ready is therefore 1 immediately after reset is released.
REQ-032 Reset asserted during DISPATCH SHALL discard all pending and held requests, and no group_done SHALL be emitted for the aborted group.

Verification
REQ-033 Routing spread: mask=4'b1111, route maps {1000,0100,0010,0001}, all ch_ready=1 -> all four ch_valid rise one edge after capture with ch_idx {3,2,1,0} on ch0..ch3; group_done pulses on the next cycle.
REQ-034 Same-channel serialization: mask=1111, all route maps 1000, ch_ready[3]=1 -> ch3 presents idx 0,1,2,3 on four consecutive cycles; group_done pulses after idx 3 has loaded.
REQ-035 Backpressure: ch_ready[3]=0 for 5 cycles with two requests on ch3 -> idx 0 is held stable for 5 cycles and idx 1 loads on the edge where ch_ready[3]=1.
REQ-036 Drops: mask=1011 with route_map[1]=0000 -> drop_cnt increments by 1 at capture; ch_idx never shows 1. A second case, mask=0000 -> no ch_valid and group_done pulses in the cycle after capture.
REQ-037 Reset mid-dispatch: assert rst while two requests are pending -> all outputs go to 0 asynchronously, no group_done is emitted, and in_ready=1 after release.
REQ-038 drop_cnt saturation: preload by driving 65535 drops -> drop_cnt stays at 0xFFFF on further drops.
